// File: rtl/lane_result_arbiter.sv
// lane_result_arbiter
// Per-lane write-back arbiter. The vector ALU (source 0) and the multiplier/FPU
// (source 1) each push result writes into their own 2-entry FIFO. One head at a
// time is presented to the lane's VRF write port under round-robin arbitration.
// Every retired entry (written, or dropped because its byte enables are all zero)
// produces a one-cycle commit pulse on the following cycle.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   fu_req_i/fu_gnt_o [1:0]   per-source push handshake (bit 0 ALU, bit 1 MFPU)
//   fu_id_i/addr/wdata/be     per-source write payload
//   vrf_req_o/vrf_gnt_i       VRF write handshake; request held until granted
//   vrf_id/addr/wdata/be_o    selected write, zero while vrf_req_o is low
//   commit_valid/id/src_o     registered retire report
//   idle_o                    both FIFOs empty and no commit pending
module lane_result_arbiter #(
    parameter int unsigned DataWidth = 128,
    parameter int unsigned AddrWidth = 9,
    parameter int unsigned IdWidth   = 3,
    parameter int unsigned StrbWidth = DataWidth / 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [1:0]                      fu_req_i,
    input  logic [1:0][IdWidth-1:0]         fu_id_i,
    input  logic [1:0][AddrWidth-1:0]       fu_addr_i,
    input  logic [1:0][DataWidth-1:0]       fu_wdata_i,
    input  logic [1:0][StrbWidth-1:0]       fu_be_i,
    output logic [1:0]                      fu_gnt_o,
    output logic                            vrf_req_o,
    output logic [IdWidth-1:0]              vrf_id_o,
    output logic [AddrWidth-1:0]            vrf_addr_o,
    output logic [DataWidth-1:0]            vrf_wdata_o,
    output logic [StrbWidth-1:0]            vrf_be_o,
    input  logic                            vrf_gnt_i,
    output logic                            commit_valid_o,
    output logic [IdWidth-1:0]              commit_id_o,
    output logic                            commit_src_o,
    output logic                            idle_o
);

    // FIFO storage and pointers, indexed [source][slot]
    logic [1:0]           count_q [2];
    logic                 wptr_q  [2];
    logic                 rptr_q  [2];
    logic [IdWidth-1:0]   id_q    [2][2];
    logic [AddrWidth-1:0] addr_q  [2][2];
    logic [DataWidth-1:0] wdata_q [2][2];
    logic [StrbWidth-1:0] be_q    [2][2];

    logic                 rr_q;
    logic                 lock_q;
    logic                 lock_src_q;
    logic                 commit_valid_q;
    logic [IdWidth-1:0]   commit_id_q;
    logic                 commit_src_q;

    logic [1:0]           nonempty_s;
    logic [1:0]           push_s;
    logic [1:0]           pop_src_s;
    logic                 sel_src_s;
    logic                 sel_valid_s;
    logic                 head_zero_s;
    logic                 vrf_req_s;
    logic                 pop_s;
    logic [IdWidth-1:0]   head_id_s;
    logic [AddrWidth-1:0] head_addr_s;
    logic [DataWidth-1:0] head_wdata_s;
    logic [StrbWidth-1:0] head_be_s;

    // Push acceptance uses only the registered count, so a full FIFO refuses
    // even when its head retires in the same cycle.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            nonempty_s[s] = (count_q[s] != 2'd0);
            push_s[s]     = fu_req_i[s] && (count_q[s] < 2'd2) && !rst_i;
        end
    end

    // Head selection, VRF request and pop decision
    always_comb begin
        // A request that was stalled last cycle keeps its source until granted.
        if (lock_q) begin
            sel_src_s = lock_src_q;
        end else if (nonempty_s == 2'b11) begin
            sel_src_s = rr_q;
        end else if (nonempty_s[1]) begin
            sel_src_s = 1'b1;
        end else begin
            sel_src_s = 1'b0;
        end
        sel_valid_s  = |nonempty_s;
        head_id_s    = id_q[sel_src_s][rptr_q[sel_src_s]];
        head_addr_s  = addr_q[sel_src_s][rptr_q[sel_src_s]];
        head_wdata_s = wdata_q[sel_src_s][rptr_q[sel_src_s]];
        head_be_s    = be_q[sel_src_s][rptr_q[sel_src_s]];
        head_zero_s  = (head_be_s == {StrbWidth{1'b0}});
        // Entries with no enabled bytes never reach the VRF; they retire directly.
        vrf_req_s    = sel_valid_s && !head_zero_s;
        pop_s        = sel_valid_s && (head_zero_s || vrf_gnt_i);
        if (pop_s) begin
            pop_src_s = sel_src_s ? 2'b10 : 2'b01;
        end else begin
            pop_src_s = 2'b00;
        end
    end

    // Output assembly; VRF payload is forced to zero when no request is shown
    always_comb begin
        fu_gnt_o       = push_s;
        vrf_req_o      = vrf_req_s;
        vrf_id_o       = vrf_req_s ? head_id_s    : {IdWidth{1'b0}};
        vrf_addr_o     = vrf_req_s ? head_addr_s  : {AddrWidth{1'b0}};
        vrf_wdata_o    = vrf_req_s ? head_wdata_s : {DataWidth{1'b0}};
        vrf_be_o       = vrf_req_s ? head_be_s    : {StrbWidth{1'b0}};
        commit_valid_o = commit_valid_q;
        commit_id_o    = commit_id_q;
        commit_src_o   = commit_src_q;
        idle_o         = !nonempty_s[0] && !nonempty_s[1] && !commit_valid_q;
    end

    // FIFO state, arbitration pointer, request lock and commit report
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < 2; s++) begin
                count_q[s] <= 2'd0;
                wptr_q[s]  <= 1'b0;
                rptr_q[s]  <= 1'b0;
                for (int k = 0; k < 2; k++) begin
                    id_q[s][k]    <= {IdWidth{1'b0}};
                    addr_q[s][k]  <= {AddrWidth{1'b0}};
                    wdata_q[s][k] <= {DataWidth{1'b0}};
                    be_q[s][k]    <= {StrbWidth{1'b0}};
                end
            end
            rr_q           <= 1'b0;
            lock_q         <= 1'b0;
            lock_src_q     <= 1'b0;
            commit_valid_q <= 1'b0;
            commit_id_q    <= {IdWidth{1'b0}};
            commit_src_q   <= 1'b0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push_s[s]) begin
                    id_q[s][wptr_q[s]]    <= fu_id_i[s];
                    addr_q[s][wptr_q[s]]  <= fu_addr_i[s];
                    wdata_q[s][wptr_q[s]] <= fu_wdata_i[s];
                    be_q[s][wptr_q[s]]    <= fu_be_i[s];
                    wptr_q[s]             <= ~wptr_q[s];
                end
                if (pop_src_s[s]) begin
                    rptr_q[s] <= ~rptr_q[s];
                end
                case ({push_s[s], pop_src_s[s]})
                    2'b10:   count_q[s] <= count_q[s] + 2'd1;
                    2'b01:   count_q[s] <= count_q[s] - 2'd1;
                    default: count_q[s] <= count_q[s];
                endcase
            end
            if (pop_s) begin
                rr_q <= ~sel_src_s;
            end
            lock_q         <= vrf_req_s && !vrf_gnt_i;
            lock_src_q     <= sel_src_s;
            commit_valid_q <= pop_s;
            commit_id_q    <= pop_s ? head_id_s : {IdWidth{1'b0}};
            commit_src_q   <= pop_s ? sel_src_s : 1'b0;
        end
    end

endmodule

// File: tb/tb_lane_result_arbiter.sv
module tb_lane_result_arbiter;

    typedef struct {
        logic [2:0]   id;
        logic [8:0]   addr;
        logic [127:0] data;
        logic [15:0]  be;
    } ent_t;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic [1:0]        fu_req_i = 2'b00;
    logic [1:0][2:0]   fu_id_i = '0;
    logic [1:0][8:0]   fu_addr_i = '0;
    logic [1:0][127:0] fu_wdata_i = '0;
    logic [1:0][15:0]  fu_be_i = '0;
    logic [1:0]        fu_gnt_o;
    logic              vrf_req_o;
    logic [2:0]        vrf_id_o;
    logic [8:0]        vrf_addr_o;
    logic [127:0]      vrf_wdata_o;
    logic [15:0]       vrf_be_o;
    logic              vrf_gnt_i = 1'b0;
    logic              commit_valid_o;
    logic [2:0]        commit_id_o;
    logic              commit_src_o;
    logic              idle_o;

    int n_tests = 0;
    int n_fail  = 0;

    lane_result_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .fu_req_i(fu_req_i), .fu_id_i(fu_id_i), .fu_addr_i(fu_addr_i),
        .fu_wdata_i(fu_wdata_i), .fu_be_i(fu_be_i), .fu_gnt_o(fu_gnt_o),
        .vrf_req_o(vrf_req_o), .vrf_id_o(vrf_id_o), .vrf_addr_o(vrf_addr_o),
        .vrf_wdata_o(vrf_wdata_o), .vrf_be_o(vrf_be_o), .vrf_gnt_i(vrf_gnt_i),
        .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o),
        .commit_src_o(commit_src_o), .idle_o(idle_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        fu_req_i  = 2'b00;
        vrf_gnt_i = 1'b0;
        rst_i     = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic set_src(input int s, input logic [2:0] id, input logic [8:0] addr,
                           input logic [15:0] be);
        fu_id_i[s]    = id;
        fu_addr_i[s]  = addr;
        fu_be_i[s]    = be;
        fu_wdata_i[s] = {4{8'hA0 + 8'(id), 24'h5A5A00 + 24'(addr)}};
    endtask

    task automatic test_reset();
        fu_req_i = 2'b00;
        rst_i = 1'b1;
        #3;
        n_tests++; if (fu_gnt_o !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got %b exp 00", fu_gnt_o); end
        n_tests++; if (vrf_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_vrf_req got %b exp 0", vrf_req_o); end
        n_tests++; if ({vrf_id_o, vrf_addr_o, vrf_be_o} !== 28'd0 || vrf_wdata_o !== 128'd0) begin
            n_fail++; $display("FAIL reset_vrf_data got %h/%h/%h exp 0", vrf_id_o, vrf_addr_o, vrf_be_o); end
        n_tests++; if ({commit_valid_o, commit_id_o, commit_src_o} !== 5'd0) begin
            n_fail++; $display("FAIL reset_commit got %b%h%b exp 0", commit_valid_o, commit_id_o, commit_src_o); end
        n_tests++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b exp 1", idle_o); end
        do_reset();
    endtask

    task automatic test_single_write();
        do_reset();
        tick(); // cycle 0
        vrf_gnt_i = 1'b1; fu_req_i = 2'b01; set_src(0, 3'd2, 9'h012, 16'hFFFF);
        #1;
        n_tests++; if (fu_gnt_o !== 2'b01) begin n_fail++; $display("FAIL single_gnt got %b exp 01", fu_gnt_o); end
        n_tests++; if (vrf_req_o !== 1'b0) begin n_fail++; $display("FAIL single_req_c0 got %b exp 0", vrf_req_o); end
        tick(); // cycle 1
        fu_req_i = 2'b00;
        #1;
        n_tests++; if (vrf_req_o !== 1'b1 || vrf_addr_o !== 9'h012 || vrf_id_o !== 3'd2) begin
            n_fail++; $display("FAIL single_vrf got req=%b addr=%h id=%0d exp 1/012/2", vrf_req_o, vrf_addr_o, vrf_id_o); end
        tick(); // cycle 2
        #1;
        n_tests++; if (commit_valid_o !== 1'b1 || commit_id_o !== 3'd2 || commit_src_o !== 1'b0) begin
            n_fail++; $display("FAIL single_commit got %b/%0d/%b exp 1/2/0", commit_valid_o, commit_id_o, commit_src_o); end
        n_tests++; if (vrf_req_o !== 1'b0 || idle_o !== 1'b0) begin
            n_fail++; $display("FAIL single_after got req=%b idle=%b exp 0/0", vrf_req_o, idle_o); end
        tick(); // cycle 3
        #1;
        n_tests++; if (idle_o !== 1'b1 || commit_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL single_idle got idle=%b cv=%b exp 1/0", idle_o, commit_valid_o); end
    endtask

    task automatic test_contention();
        logic [2:0] exp_ids [6];
        exp_ids = '{3'd1, 3'd4, 3'd0, 3'd2, 3'd0, 3'd6};
        do_reset();
        tick(); // c0: both push
        vrf_gnt_i = 1'b1; fu_req_i = 2'b11;
        set_src(0, 3'd1, 9'h010, 16'hFFFF); set_src(1, 3'd4, 9'h020, 16'hFFFF);
        #1;
        n_tests++; if (fu_gnt_o !== 2'b11) begin n_fail++; $display("FAIL cont_gnt got %b exp 11", fu_gnt_o); end
        for (int c = 1; c <= 7; c++) begin
            tick();
            fu_req_i = 2'b00;
            if (c == 3) begin fu_req_i = 2'b01; set_src(0, 3'd2, 9'h030, 16'h00F0); end
            if (c == 5) begin
                fu_req_i = 2'b11;
                set_src(0, 3'd3, 9'h040, 16'hFFFF); set_src(1, 3'd6, 9'h050, 16'h0F0F);
            end
            #1;
            if (c == 1 || c == 2 || c == 4) begin
                n_tests++; if (vrf_req_o !== 1'b1 || vrf_id_o !== exp_ids[c-1]) begin
                    n_fail++; $display("FAIL cont_order c%0d got req=%b id=%0d exp 1/%0d", c, vrf_req_o, vrf_id_o, exp_ids[c-1]); end
            end
            if (c == 6) begin
                n_tests++; if (vrf_id_o !== 3'd6) begin n_fail++; $display("FAIL cont_rr_mfpu_first got %0d exp 6", vrf_id_o); end
            end
            if (c == 7) begin
                n_tests++; if (vrf_id_o !== 3'd3) begin n_fail++; $display("FAIL cont_rr_alu_second got %0d exp 3", vrf_id_o); end
            end
            if (c == 3) begin
                n_tests++; if (commit_id_o !== 3'd4 || commit_src_o !== 1'b1) begin
                    n_fail++; $display("FAIL cont_commit got id=%0d src=%b exp 4/1", commit_id_o, commit_src_o); end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        tick(); // c0: MFPU pushes
        fu_req_i = 2'b10; set_src(1, 3'd3, 9'h055, 16'h00FF);
        for (int c = 1; c <= 6; c++) begin
            tick();
            fu_req_i  = (c == 1) ? 2'b01 : 2'b00;
            if (c == 1) set_src(0, 3'd1, 9'h033, 16'hFFFF);
            vrf_gnt_i = (c == 6);
            #1;
            n_tests++; if (vrf_req_o !== 1'b1 || vrf_id_o !== 3'd3 || vrf_addr_o !== 9'h055 || vrf_be_o !== 16'h00FF) begin
                n_fail++; $display("FAIL bp_hold c%0d got req=%b id=%0d addr=%h be=%h exp 1/3/055/00ff",
                                   c, vrf_req_o, vrf_id_o, vrf_addr_o, vrf_be_o); end
        end
        tick(); // c7
        #1;
        n_tests++; if (vrf_req_o !== 1'b1 || vrf_id_o !== 3'd1 || vrf_addr_o !== 9'h033) begin
            n_fail++; $display("FAIL bp_alu_next got req=%b id=%0d addr=%h exp 1/1/033", vrf_req_o, vrf_id_o, vrf_addr_o); end
        n_tests++; if (commit_valid_o !== 1'b1 || commit_id_o !== 3'd3 || commit_src_o !== 1'b1) begin
            n_fail++; $display("FAIL bp_commit got %b/%0d/%b exp 1/3/1", commit_valid_o, commit_id_o, commit_src_o); end
    endtask

    task automatic test_full_fifo();
        logic [1:0] exp_g [6];
        exp_g = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            tick();
            fu_req_i  = 2'b01;
            set_src(0, 3'(c < 3 ? c + 1 : 3), 9'(9'h100 + c), 16'hFFFF);
            vrf_gnt_i = (c == 4);
            #1;
            n_tests++; if (fu_gnt_o !== exp_g[c]) begin
                n_fail++; $display("FAIL full_gnt c%0d got %b exp %b", c, fu_gnt_o, exp_g[c]); end
        end
        for (int c = 6; c < 10; c++) begin
            tick();
            fu_req_i  = 2'b00;
            vrf_gnt_i = 1'b1;
            #1;
            if (c == 6 || c == 7) begin
                n_tests++; if (vrf_req_o !== 1'b1 || vrf_id_o !== 3'(c - 4)) begin
                    n_fail++; $display("FAIL full_drain c%0d got req=%b id=%0d exp 1/%0d", c, vrf_req_o, vrf_id_o, c - 4); end
            end
            if (c == 9) begin
                n_tests++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL full_idle got %b exp 1", idle_o); end
            end
        end
    endtask

    task automatic test_zero_be();
        do_reset();
        tick(); // c0
        vrf_gnt_i = 1'b1; fu_req_i = 2'b01; set_src(0, 3'd5, 9'h077, 16'h0000);
        #1;
        tick(); // c1
        fu_req_i = 2'b00;
        #1;
        n_tests++; if (vrf_req_o !== 1'b0) begin n_fail++; $display("FAIL zbe_req got %b exp 0", vrf_req_o); end
        tick(); // c2
        #1;
        n_tests++; if (commit_valid_o !== 1'b1 || commit_id_o !== 3'd5 || commit_src_o !== 1'b0 || vrf_req_o !== 1'b0) begin
            n_fail++; $display("FAIL zbe_commit got %b/%0d/%b req=%b exp 1/5/0 req=0", commit_valid_o, commit_id_o, commit_src_o, vrf_req_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            tick();
            fu_req_i = 2'b11;
            set_src(0, 3'(c + 1), 9'(9'h0A0 + c), 16'hFFFF); set_src(1, 3'(c + 4), 9'(9'h0B0 + c), 16'hFFFF);
        end
        tick();
        rst_i = 1'b1;
        #1;
        n_tests++; if (fu_gnt_o !== 2'b00 || vrf_req_o !== 1'b0 || vrf_addr_o !== 9'h000 || idle_o !== 1'b1 || commit_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_outputs got gnt=%b req=%b addr=%h idle=%b cv=%b exp 00/0/000/1/0",
                               fu_gnt_o, vrf_req_o, vrf_addr_o, idle_o, commit_valid_o); end
        tick();
        rst_i = 1'b0; fu_req_i = 2'b00; vrf_gnt_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            #1;
            n_tests++; if (vrf_req_o !== 1'b0 || commit_valid_o !== 1'b0 || idle_o !== 1'b1) begin
                n_fail++; $display("FAIL rstmid_stale c%0d got req=%b cv=%b idle=%b exp 0/0/1", c, vrf_req_o, commit_valid_o, idle_o); end
        end
    endtask

    // Randomised traffic against a queue-based model of the arbitration rules
    task automatic test_random();
        ent_t q0[$];
        ent_t q1[$];
        ent_t head;
        ent_t e;
        bit rr = 1'b0, lk = 1'b0, lks = 1'b0, sel, valid, ereq, epop;
        bit cv = 1'b0, csrc = 1'b0;
        logic [2:0] cid = 3'd0;
        logic [1:0] eg;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            tick();
            for (int s = 0; s < 2; s++) begin
                fu_req_i[s]   = ($urandom_range(0, 2) != 0);
                fu_id_i[s]    = 3'($urandom);
                fu_addr_i[s]  = 9'($urandom);
                fu_wdata_i[s] = {$urandom, $urandom, $urandom, $urandom};
                fu_be_i[s]    = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom | 1);
            end
            vrf_gnt_i = ($urandom_range(0, 9) < 6);
            #1;
            eg[0] = fu_req_i[0] && (q0.size() < 2);
            eg[1] = fu_req_i[1] && (q1.size() < 2);
            valid = (q0.size() + q1.size()) > 0;
            if (lk) sel = lks;
            else if (q0.size() > 0 && q1.size() > 0) sel = rr;
            else sel = (q1.size() > 0);
            head = '{3'd0, 9'd0, 128'd0, 16'd0};
            if (valid) head = sel ? q1[0] : q0[0];
            ereq = valid && (head.be != 16'h0000);
            if (!ereq) head = '{3'd0, 9'd0, 128'd0, 16'd0};
            n_tests++; if (fu_gnt_o !== eg) begin n_fail++; $display("FAIL rnd_gnt c%0d got %b exp %b", c, fu_gnt_o, eg); end
            n_tests++; if (vrf_req_o !== ereq) begin n_fail++; $display("FAIL rnd_req c%0d got %b exp %b", c, vrf_req_o, ereq); end
            n_tests++; if (vrf_id_o !== head.id || vrf_addr_o !== head.addr || vrf_be_o !== head.be || vrf_wdata_o !== head.data) begin
                n_fail++; $display("FAIL rnd_vrf c%0d got id=%0d addr=%h be=%h exp id=%0d addr=%h be=%h",
                                   c, vrf_id_o, vrf_addr_o, vrf_be_o, head.id, head.addr, head.be); end
            n_tests++; if (commit_valid_o !== cv || commit_id_o !== cid || commit_src_o !== csrc) begin
                n_fail++; $display("FAIL rnd_commit c%0d got %b/%0d/%b exp %b/%0d/%b",
                                   c, commit_valid_o, commit_id_o, commit_src_o, cv, cid, csrc); end
            n_tests++; if (idle_o !== (q0.size() == 0 && q1.size() == 0 && !cv)) begin
                n_fail++; $display("FAIL rnd_idle c%0d got %b", c, idle_o); end
            // advance the model across the coming clock edge
            epop = valid && (!ereq || vrf_gnt_i);
            lk   = ereq && !vrf_gnt_i;
            lks  = sel;
            cv   = epop;
            cid  = 3'd0;
            csrc = 1'b0;
            if (epop) begin
                if (sel) begin cid = q1[0].id; void'(q1.pop_front()); end
                else     begin cid = q0[0].id; void'(q0.pop_front()); end
                csrc = sel;
                rr   = !sel;
            end
            if (eg[0]) begin e = '{fu_id_i[0], fu_addr_i[0], fu_wdata_i[0], fu_be_i[0]}; q0.push_back(e); end
            if (eg[1]) begin e = '{fu_id_i[1], fu_addr_i[1], fu_wdata_i[1], fu_be_i[1]}; q1.push_back(e); end
        end
        fu_req_i  = 2'b00;
        vrf_gnt_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_backpressure();
        test_full_fifo();
        test_zero_be();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lane_result_arbiter.md
# lane_result_arbiter

Per-lane write-back arbiter that accepts result write requests from the vector ALU and the multiplier/FPU, buffers them, and presents one write at a time to the lane's vector register file (VRF) port. It responds to the functional units' `result_req`/`result_gnt` handshake and initiates a `req`/`gnt` handshake toward the VRF. It also reports a commit pulse per retired write so the lane sequencer can track write progress per instruction.

## Interface

Parameters:

- `DataWidth`, default 128: result data width (SIMD ELEN word).
- `AddrWidth`, default 9: VRF element address width.
- `IdWidth`, default 3: vector instruction ID width (`vid_t`).
- `StrbWidth`, fixed to `DataWidth/8`: byte-enable width. Do not override.

Ports:

- `clk_i`  in  1  clock; every flop is on its rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `fu_req_i`  in  2  result write request; bit 0 = ALU, bit 1 = MFPU.
- `fu_id_i`  in  2×IdWidth  instruction ID per source.
- `fu_addr_i`  in  2×AddrWidth  VRF address per source.
- `fu_wdata_i`  in  2×DataWidth  write data per source.
- `fu_be_i`  in  2×StrbWidth  byte enables per source.
- `fu_gnt_o`  out  2  request accepted this cycle, per source.
- `vrf_req_o`  out  1  VRF write request.
- `vrf_id_o`, `vrf_addr_o`, `vrf_wdata_o`, `vrf_be_o`  out  IdWidth / AddrWidth / DataWidth / StrbWidth  selected write.
- `vrf_gnt_i`  in  1  VRF accepted the write this cycle.
- `commit_valid_o`  out  1  one-cycle pulse per retired entry.
- `commit_id_o`  out  IdWidth  ID of the retired entry.
- `commit_src_o`  out  1  source of the retired entry (0 = ALU, 1 = MFPU).
- `idle_o`  out  1  both buffers are empty and no commit is pending.

## Operation

- Each source has a 2-entry FIFO holding {id, addr, wdata, be}.
- Push: `fu_gnt_o[s] = fu_req_i[s] && count[s] < 2`. The entry is pushed on that cycle.
  - `fu_gnt_o` depends only on registered count and `fu_req_i`. There is no combinational path from `vrf_gnt_i`.
  - A full FIFO refuses the push even when its head is popped in the same cycle.
- Head selection uses a round-robin pointer `rr` (0 = ALU preferred).
  - Only one FIFO non-empty: select it.
  - Both non-empty: select source `rr`.
  - While `vrf_req_o && !vrf_gnt_i`, the selection and all `vrf_*` outputs are locked. The request is never withdrawn or changed until granted.
- Pop on `vrf_req_o && vrf_gnt_i`:
  - The selected head is removed.
  - `rr` is set to the other source.
- Zero-byte-enable entry: if the selected head has `be == 0`, it is not sent to the VRF. `vrf_req_o` stays 0 and the entry is popped that cycle as a drop. `rr` updates as for a normal pop.
- Commit: every pop, normal or drop, registers `commit_valid_o=1`, `commit_id_o`, and `commit_src_o` for exactly the following cycle.
- `idle_o = (count[0]==0) && (count[1]==0) && !commit_valid_o`.
- The two FIFOs hold independent counts, 0..2. Read and write pointers are 1 bit each and wrap modulo 2.
- Simultaneous push and pop on the same FIFO (count 1): count is unchanged and ordering is preserved.

## Timing

- Reset values (asynchronous on `rst_i`):
  - FIFOs empty, `rr=0`.
  - `fu_gnt_o=0`, `vrf_req_o=0`, `vrf_id_o/addr_o/wdata_o/be_o=0`.
  - `commit_valid_o=0`, `commit_id_o=0`, `commit_src_o=0`, `idle_o=1`.
- Reset mid-operation discards all buffered entries. No commit is issued for them.
- Latency:
  - A push at cycle N makes the entry eligible at N+1.
  - With an empty opposite FIFO, `vrf_req_o` rises at N+1.
  - A grant at cycle M produces `commit_valid_o` at M+1.
- Throughput: one VRF write per cycle while `vrf_gnt_i` stays high.
- When both sources are backlogged, grants alternate ALU/MFPU.
- `vrf_*` data outputs are 0 whenever `vrf_req_o=0`.

## Test plan

- Single ALU write: `fu_req_i=01`, addr 0x012, be 0xFFFF, id 2 at cycle 0 → `fu_gnt_o=01` at cycle 0; `vrf_req_o=1`, addr 0x012 at cycle 1; with `vrf_gnt_i=1`, `commit_valid_o=1`, id 2, src 0 at cycle 2.
- Contention: both sources push in the same cycle, `vrf_gnt_i` held 1 → ALU written first, then MFPU. A second pair is written MFPU first (`rr` toggled), then ALU.
- Backpressure: MFPU entry pending, `vrf_gnt_i=0` for 5 cycles, ALU pushes meanwhile → `vrf_*` holds the MFPU entry unchanged for all 5 cycles; ALU is written right after the grant.
- Full FIFO: ALU requests on 3 consecutive cycles with `vrf_gnt_i=0` → `fu_gnt_o[0]`=1,1,0. The third request is held until the cycle after the first pop, then granted.
- Zero byte enable: ALU pushes be=0, id 5 → `vrf_req_o` never rises for it; `commit_valid_o=1`, id 5, src 0 two cycles after the push.
- Reset mid-operation: both FIFOs full, assert `rst_i` → all outputs reach reset values immediately; after release no stale writes or commits appear and `idle_o=1`.
